// File: rtl/request_pending_encoder.sv
// Sticky request collector feeding a registered lowest-index-first encoder.
// Events accumulate in a pending register and each one is handed out once over valid/ready.
module request_pending_encoder #(
  parameter int DATA_WIDTH  = 4,
  parameter int EDGE_DETECT = 1
) (
  input  logic                          i_clock,
  input  logic                          i_reset,
  input  logic [DATA_WIDTH-1:0]         i_req,
  input  logic [DATA_WIDTH-1:0]         i_mask,
  input  logic                          i_clear,
  input  logic                          i_ready,
  output logic                          o_valid,
  output logic [$clog2(DATA_WIDTH)-1:0] o_index,
  output logic [DATA_WIDTH-1:0]         o_pending
);

  localparam int IW = $clog2(DATA_WIDTH);

  logic [DATA_WIDTH-1:0] req_q;
  logic [DATA_WIDTH-1:0] pend;
  logic [DATA_WIDTH-1:0] evt;
  logic [DATA_WIDTH-1:0] elig;
  logic [DATA_WIDTH-1:0] load_oh;
  logic [IW-1:0]         sel;
  logic                  load_en;
  logic                  load;

  always_comb begin
    if (EDGE_DETECT != 0) evt = i_req & ~req_q;
    else                  evt = i_req;
  end

  // Scan from the top down so the lowest set bit wins.
  always_comb begin
    elig = pend & i_mask;
    sel  = '0;
    for (int i = DATA_WIDTH - 1; i >= 0; i--) begin
      if (elig[i]) sel = IW'(i);
    end
  end

  always_comb begin
    load_en = !o_valid || i_ready;
    load    = load_en && (elig != '0);
    load_oh = load ? (DATA_WIDTH'(1) << sel) : '0;
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      req_q   <= '0;
      pend    <= '0;
      o_valid <= 1'b0;
      o_index <= '0;
    end else begin
      req_q <= i_req;
      // Clear wins over same-cycle events; the output register is left alone.
      if (i_clear) pend <= '0;
      else         pend <= (pend & ~load_oh) | evt;
      if (load_en) begin
        o_valid <= load;
        if (load) o_index <= sel;
      end
    end
  end

  assign o_pending = pend;

endmodule

// File: tb/tb_request_pending_encoder.sv
// Bench for request_pending_encoder: edge-mode and level-mode instances share stimulus,
// a per-cycle reference model is compared every cycle, plus directed literal checks.
module tb_request_pending_encoder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] req = '0;
  logic [3:0] mask = 4'b1111;
  logic       clear = 1'b0;
  logic       ready = 1'b1;

  logic       e_valid, l_valid;
  logic [1:0] e_index, l_index;
  logic [3:0] e_pending, l_pending;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  request_pending_encoder #(.DATA_WIDTH(4), .EDGE_DETECT(1)) dut_e (
    .i_clock(clk), .i_reset(rst), .i_req(req), .i_mask(mask), .i_clear(clear),
    .i_ready(ready), .o_valid(e_valid), .o_index(e_index), .o_pending(e_pending)
  );

  request_pending_encoder #(.DATA_WIDTH(4), .EDGE_DETECT(0)) dut_l (
    .i_clock(clk), .i_reset(rst), .i_req(req), .i_mask(mask), .i_clear(clear),
    .i_ready(ready), .o_valid(l_valid), .o_index(l_index), .o_pending(l_pending)
  );

  // Reference model, index 0 = edge mode, 1 = level mode.
  bit m_prev [2][4];
  bit m_pend [2][4];
  bit m_valid[2];
  int m_idx  [2];

  int xfer_e = 0, xfer_l = 0, xfer_l0 = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int m = 0; m < 2; m++) begin
        for (int b = 0; b < 4; b++) begin
          m_prev[m][b] <= 1'b0;
          m_pend[m][b] <= 1'b0;
        end
        m_valid[m] <= 1'b0;
        m_idx[m]   <= 0;
      end
    end else begin
      if (e_valid && ready) xfer_e <= xfer_e + 1;
      if (l_valid && ready) begin
        xfer_l <= xfer_l + 1;
        if (l_index == 2'd0) xfer_l0 <= xfer_l0 + 1;
      end
      for (int m = 0; m < 2; m++) begin
        int  first;
        bit  np[4];
        first = -1;
        for (int b = 0; b < 4; b++) begin
          np[b] = m_pend[m][b];
          if (first < 0 && m_pend[m][b] && mask[b]) first = b;
        end
        if (!m_valid[m] || ready) begin
          if (first >= 0) begin
            m_valid[m] <= 1'b1;
            m_idx[m]   <= first;
            np[first]   = 1'b0;
          end else begin
            m_valid[m] <= 1'b0;
          end
        end
        for (int b = 0; b < 4; b++) begin
          bit ev;
          ev = (m == 0) ? (req[b] && !m_prev[m][b]) : req[b];
          m_pend[m][b] <= clear ? 1'b0 : (np[b] | ev);
          m_prev[m][b] <= req[b];
        end
      end
    end
  end

  function automatic int model_pend(input int m);
    int v = 0;
    for (int b = 0; b < 4; b++) if (m_pend[m][b]) v += (1 << b);
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_loop();
    forever begin
      @(negedge clk);
      if (!rst) begin
        chk("model_e_valid", int'(e_valid), int'(m_valid[0]));
        chk("model_e_index", int'(e_index), m_idx[0]);
        chk("model_e_pend",  int'(e_pending), model_pend(0));
        chk("model_l_valid", int'(l_valid), int'(m_valid[1]));
        chk("model_l_index", int'(l_index), m_idx[1]);
        chk("model_l_pend",  int'(l_pending), model_pend(1));
      end
    end
  endtask

  task automatic nedge(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int base_e, base_l, base_l0;
    fork
      compare_loop();
    join_none

    #1;
    chk("reset_valid", int'(e_valid), 0);
    chk("reset_index", int'(e_index), 0);
    chk("reset_pend",  int'(e_pending), 0);
    nedge(2);
    rst = 1'b0;

    // Single pulse
    nedge(1); req = 4'b0100;
    nedge(1); chk("pulse_pend_e1", int'(e_pending), 4); req = 4'b0000;
    nedge(1);
    chk("pulse_valid_e2", int'(e_valid), 1);
    chk("pulse_index_e2", int'(e_index), 2);
    chk("pulse_pend_e2",  int'(e_pending), 0);
    nedge(1); chk("pulse_valid_e3", int'(e_valid), 0);

    // Priority with backpressure
    ready = 1'b0; req = 4'b1010; base_e = xfer_e;
    nedge(1); req = 4'b0000;
    for (int i = 0; i < 5; i++) begin
      nedge(1);
      chk("bp_hold_valid", int'(e_valid), 1);
      chk("bp_hold_index", int'(e_index), 1);
      chk("bp_hold_pend",  int'(e_pending), 8);
    end
    ready = 1'b1;
    nedge(1);
    chk("bp_second_valid", int'(e_valid), 1);
    chk("bp_second_index", int'(e_index), 3);
    nedge(1); chk("bp_drained", int'(e_valid), 0);
    chk("bp_xfers", xfer_e - base_e, 2);

    // Mask
    mask = 4'b1101; req = 4'b0010;
    nedge(1); req = 4'b0000;
    for (int i = 0; i < 10; i++) begin
      nedge(1);
      chk("mask_pend",  int'(e_pending), 2);
      chk("mask_valid", int'(e_valid), 0);
    end
    mask = 4'b1111;
    nedge(1);
    chk("unmask_valid", int'(e_valid), 1);
    chk("unmask_index", int'(e_index), 1);
    chk("unmask_pend",  int'(e_pending), 0);
    nedge(1);

    // Level versus edge
    base_e = xfer_e; base_l = xfer_l; base_l0 = xfer_l0;
    req = 4'b0001;
    nedge(10); req = 4'b0000;
    nedge(4);
    chk("edge_xfers",   xfer_e - base_e, 1);
    chk("level_xfers",  xfer_l - base_l, 10);
    chk("level_idx0",   xfer_l0 - base_l0, 10);

    // Re-arm while the same index is held in the output
    ready = 1'b0; req = 4'b0100;
    nedge(1); req = 4'b0000;
    nedge(1);
    chk("rearm_held_index", int'(e_index), 2);
    req = 4'b0100;
    nedge(1); req = 4'b0000;
    nedge(1);
    chk("rearm_pend", int'(e_pending), 4);
    base_e = xfer_e; ready = 1'b1;
    nedge(1);
    chk("rearm_b2b_valid", int'(e_valid), 1);
    chk("rearm_b2b_index", int'(e_index), 2);
    nedge(1);
    chk("rearm_xfers", xfer_e - base_e, 2);
    chk("rearm_done",  int'(e_valid), 0);

    // Event on a bit in the same cycle it is loaded
    mask = 4'b1110; req = 4'b0001;
    nedge(1); req = 4'b0000;
    nedge(1); mask = 4'b1111; req = 4'b0001;
    nedge(1);
    chk("simul_pend",  int'(e_pending), 1);
    chk("simul_index", int'(e_index), 0);
    req = 4'b0000;
    nedge(3);

    // Clear with an entry held in the output
    ready = 1'b0; req = 4'b0111;
    nedge(1); req = 4'b0000;
    nedge(1);
    chk("clr_pre_pend",  int'(e_pending), 6);
    chk("clr_pre_index", int'(e_index), 0);
    clear = 1'b1; req = 4'b1000;
    nedge(1);
    clear = 1'b0; req = 4'b0000;
    chk("clr_pend",  int'(e_pending), 0);
    chk("clr_valid", int'(e_valid), 1);
    chk("clr_index", int'(e_index), 0);
    nedge(3);
    base_e = xfer_e; ready = 1'b1;
    nedge(4);
    chk("clr_xfers", xfer_e - base_e, 1);
    chk("clr_idle",  int'(e_valid), 0);

    // Asynchronous reset mid-transfer
    req = 4'b0110;
    nedge(1); req = 4'b0000;
    nedge(1);
    chk("prerst_index", int'(e_index), 1);
    #2 rst = 1'b1;
    #1;
    chk("arst_valid", int'(e_valid), 0);
    chk("arst_index", int'(e_index), 0);
    chk("arst_pend",  int'(e_pending), 0);
    chk("arst_l_pend", int'(l_pending), 0);
    nedge(1); rst = 1'b0;
    nedge(3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
